// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC/count/payload/checksum frames from a byte
// stream and writes 18-bit instruction words into the PicoBlaze program RAM,
// holding the processor in reset until a frame loads with a good checksum.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [17:0]       wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned       GAP_W    = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT - 1);
  localparam logic [16:0]       MAX_N    = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_WRITE, S_CHK
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          chk_q, chk_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [1:0]          b0_q, b0_d;
  logic [7:0]          b1_q, b1_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [17:0]         wr_data_q, wr_data_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic [15:0]         n_new;

  assign rx_ready  = (state_q != S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = rx_valid & rx_ready;
  assign n_new     = {n_q[15:8], rx_data};
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

  // Next-state and next-output decode for the frame parser.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves a signal unassigned (no latches).
    state_d     = state_q;
    n_d         = n_q;
    addr_d      = addr_q;
    chk_d       = chk_q;
    gap_d       = gap_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    unique case (state_q)
      S_IDLE: if (accept && rx_data == SYNC_BYTE) begin
        state_d     = S_CNT_HI;
        cpu_reset_d = 1'b1;
        done_d      = 1'b0;
        error_d     = 1'b0;
        chk_d       = '0;
        addr_d      = '0;
        gap_d       = '0;
      end
      S_CNT_HI: if (accept) begin
        n_d[15:8] = rx_data;
        chk_d     = chk_q ^ rx_data;
        state_d   = S_CNT_LO;
      end
      S_CNT_LO: if (accept) begin
        n_d[7:0] = rx_data;
        chk_d    = chk_q ^ rx_data;
        if (n_new == 16'd0 || {1'b0, n_new} > MAX_N) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_B0;
        end
      end
      S_B0: if (accept) begin
        b0_d    = rx_data[1:0];
        chk_d   = chk_q ^ rx_data;
        state_d = S_B1;
      end
      S_B1: if (accept) begin
        b1_d    = rx_data;
        chk_d   = chk_q ^ rx_data;
        state_d = S_B2;
      end
      S_B2: if (accept) begin
        chk_d     = chk_q ^ rx_data;
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = {b0_q, b1_q, rx_data};
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        state_d = (16'(addr_q) == n_q - 16'd1) ? S_CHK : S_B0;
      end
      S_CHK: if (accept) begin
        if (rx_data == chk_q) begin
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
        end else begin
          error_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte gap watchdog; only fires on a cycle with no accepted byte.
    if (state_q != S_IDLE && state_q != S_WRITE) begin
      if (accept) begin
        gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
        gap_d   = '0;
        error_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      addr_q      <= '0;
      chk_q       <= '0;
      gap_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      chk_q       <= chk_d;
      gap_q       <= gap_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader for the PicoBlaze instruction memory. It consumes a framed byte stream (from a UART receiver or host bridge) and produces 18-bit instruction writes on the program memory's write port. It holds the processor in reset while loading and reports completion or failure. It is the writer that fills the 1024×18 program RAM that the processor fetches from.

## Interface
Parameters:
- ADDR_W, 10: instruction address width; maximum word count is 2^ADDR_W.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT, 50000: idle cycles allowed between accepted bytes inside a frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  single-cycle write strobe to program memory.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  18  instruction word.
- cpu_reset  out  1  processor reset request, active-high.
- busy  out  1  frame in progress (state ≠ IDLE).
- done  out  1  last frame loaded with a good checksum; sticky.
- error  out  1  last frame failed; sticky.

## Operation
- A byte is accepted on a rising edge where rx_valid & rx_ready.
- Frame format: SYNC_BYTE, CNT_HI, CNT_LO, then N×{B0, B1, B2}, then CHK.
  - N = {CNT_HI, CNT_LO}.
  - Each word is assembled as wr_data = {B0[1:0], B1, B2]. B0[7:2] is ignored.
  - CHK = XOR of CNT_HI, CNT_LO and every payload byte. SYNC_BYTE is excluded.
- States: IDLE, CNT_HI, CNT_LO, B0, B1, B2, WRITE, CHK.
- IDLE:
  - Non-SYNC bytes are accepted and discarded.
  - On SYNC_BYTE: go to CNT_HI, set cpu_reset=1, clear done and error, clear the checksum accumulator, set the address counter to 0.
- CNT_HI → CNT_LO on accepted byte.
- CNT_LO, on accepted byte:
  - If N==0 or N>2^ADDR_W: set error and go to IDLE.
  - Otherwise go to B0.
- B0 → B1 → B2, one accepted byte each.
- B2 → WRITE on the accepted byte.
- WRITE (exactly one cycle):
  - wr_en=1 with the current address and the assembled word; rx_ready=0.
  - Address increments afterwards.
  - Go to CHK if this was word N−1, else go to B0.
- CHK, on accepted byte:
  - Match: set done, clear cpu_reset.
  - Mismatch: set error; cpu_reset stays 1.
  - Either way go to IDLE.
  - Memory already written is not rolled back. The processor stays in reset until a later frame succeeds.
- Timeout:
  - In any state other than IDLE/WRITE, the gap counter increments each cycle with no accepted byte and resets on acceptance.
  - When it reaches TIMEOUT: set error and go to IDLE. cpu_reset stays 1.
- rx_ready=1 in every state except WRITE.
- Reset (asynchronous, any time including mid-frame), all outputs return to reset values:
  - state=IDLE.
  - cpu_reset=0, wr_en=0, wr_addr=0, wr_data=0.
  - done=0, error=0, busy=0.
  - rx_ready=1.
  - Checksum and gap counter = 0.

## Timing
- Registered outputs; no combinational path from rx_* to any output except none (rx_ready depends only on state).
- wr_en rises the cycle after B2 is accepted and lasts one cycle. wr_addr/wr_data are stable while wr_en=1 and hold their values afterwards.
- With rx_valid held high continuously, throughput is one word per 4 cycles.
- cpu_reset rises the cycle after SYNC_BYTE is accepted and falls the cycle after a good CHK is accepted.
- done/error update the cycle after the deciding byte or timeout. They remain until the next SYNC_BYTE or reset.
- Timeout: error asserts TIMEOUT cycles after the last accepted byte.
- busy deasserts in the same cycle that done/error asserts.

## Test plan
- Good load:
  - Stimulus: A5 00 02 01 23 45 02 AB CD 01.
  - Required: wr_en at addr 0 data 0x12345, then addr 1 data 0x2ABCD; done=1, error=0; cpu_reset 0→1→0.
- Bad checksum:
  - Stimulus: same frame with CHK=00.
  - Required: both writes occur; error=1, done=0; cpu_reset stays 1 until the good frame is replayed, then falls.
- Illegal count:
  - Stimulus: A5 00 00, and separately A5 04 01 (1025).
  - Required: error=1 after CNT_LO; no wr_en; busy=0.
- Timeout:
  - Stimulus: TIMEOUT=16; A5 00 01 01, then silence.
  - Required: error=1 exactly 16 cycles after the last byte; state IDLE; a following A5 clears error.
- Noise and reset:
  - Stimulus: 11 22 in IDLE.
  - Required: bytes ignored, busy=0.
  - Stimulus: rst_n low during B1.
  - Required: all outputs at reset values immediately; cpu_reset=0; next frame loads from addr 0.
- Back-pressure:
  - Stimulus: rx_valid held high for a 4-word frame.
  - Required: rx_ready low exactly one cycle per word (4 total); 4 writes at addresses 0–3.
